ssd_scan_controller: RTL and testbench
======================================

Name: ssd_scan_controller

Overview:
- Time-multiplexed scan controller for a common-anode seven-segment bank.
- Shares one SevenSegmentDisplayDecoder instance between NUM_DIGITS digits: presents one nibble on nOut, which drives the decoder's nIn, and enables one digit at a time.
- Sits between the datapath value source (register or bus display) and the board display pins.
- Gives tear-free value updates with a frame-boundary commit handshake.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; range 2..8.
- PRESCALE, 50000, clk cycles per digit slot; must be at least 1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- en  input  1  scan enable; 0 = display off
- load  input  1  request to display dataIn; single-cycle strobe or level
- dataIn  input  4*NUM_DIGITS  value to display; nibble k shown on digit k; digit 0 is least significant
- ldAck  output  1  one-cycle pulse when a loaded value is committed to the display
- frameDone  output  1  one-cycle pulse at each scan-frame wrap
- nOut  output  4  nibble for the current digit; connects to the decoder's nIn
- digitSel_L  output  NUM_DIGITS  active-low digit enables; at most one bit low

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high, and takes priority over all other inputs.
- Reset values:
  - state=OFF; idx=0; prescale count=0.
  - shadow=0; holding=0; pending=0.
  - ldAck=0; frameDone=0; nOut=0; digitSel_L=all ones.
- Registered state: state {OFF, SCAN}, idx, cnt, shadow (displayed value), holding (queued value), pending.
- Outputs: nOut and digitSel_L are decoded from registered state only. There is no combinational path from any input to nOut, digitSel_L, ldAck or frameDone.
- OFF state:
  - digitSel_L=all ones; nOut=shadow[3:0]; cnt held at 0.
  - load=1: shadow<=dataIn; ldAck=1 on the following cycle.
  - en=1: go to SCAN next cycle with idx=0, cnt=0.
- SCAN state:
  - digitSel_L[idx]=0, all other bits 1; nOut=shadow[4*idx+3:4*idx].
  - cnt increments each cycle. tick = (cnt==PRESCALE-1); on tick cnt<=0.
  - On tick, idx<=idx+1. When idx==NUM_DIGITS-1 it wraps to 0 (wrap event).
  - Wrap event: frameDone=1 on the next cycle. If pending=1 or load=1 on the wrap cycle, shadow<=commit value, pending<=0, and ldAck=1 next cycle.
  - Commit value: dataIn if load=1 on the wrap cycle, otherwise holding.
  - load=1 on a non-wrap cycle: holding<=dataIn, pending<=1. Repeated loads before the wrap overwrite holding (last wins) and produce exactly one ldAck.
  - en=0: go to OFF next cycle; idx<=0; cnt<=0. pending and holding are kept, and are committed at the next load or next wrap.
- PRESCALE=1: tick every cycle; one full frame = NUM_DIGITS cycles.
- Simultaneous en=0 and wrap: the wrap commit and frameDone still happen; the state still goes to OFF.
- rst mid-frame or mid-pending: all registers return to reset values on that edge; any queued value is discarded and no ldAck is generated.
- ldAck and frameDone are never high for more than one consecutive cycle from a single event.

Optional Feature:
- Macro: SSD_LEADING_ZERO_BLANK_EN.
- When defined:
  - In SCAN, digit k with k>0 is blanked (digitSel_L[k] held 1 during its slot) if nibbles k..NUM_DIGITS-1 of shadow are all zero.
  - Digit 0 is always shown.
  - Slot timing, idx sequencing and frameDone are unchanged.
- When undefined: every digit is enabled in its slot, including leading zeros.

Test Plan (NUM_DIGITS=4, PRESCALE=3):
- Reset then en=1, load=1 in OFF with dataIn=16'h1234 -> ldAck pulses once. digitSel_L steps 1110,1101,1011,0111, each held for 3 cycles. nOut steps 4,3,2,1. frameDone pulses every 12 cycles.
- In SCAN with shadow=16'h1234, load 16'hABCD at idx=1 -> nOut still shows 3,2,1 for the rest of the frame. ldAck and frameDone pulse together after the wrap. The next frame shows D,C,B,A.
- Loads 16'h1111 then 16'h2222 within one frame -> exactly one ldAck. The next frame shows 2,2,2,2.
- en=0 mid-frame at idx=2 -> digitSel_L=1111 on the next cycle. Re-enabling restarts at idx=0 with cnt=0.
- rst asserted with pending=1 at idx=3 -> all outputs return to reset values next edge; no ldAck; shadow=0.
- With SSD_LEADING_ZERO_BLANK_EN and shadow=16'h0050 -> digits 0 and 1 are enabled, digits 2 and 3 stay 1. With shadow=0, only digit 0 is enabled, showing 0.

Source files
------------

// File: rtl/ssd_scan_controller.sv
// ssd_scan_controller
//
// Time-multiplexed scan controller for a common-anode seven-segment bank.
// One shared SevenSegmentDisplayDecoder is fed through nOut, and one digit is
// enabled at a time through digitSel_L. New values are taken in with a
// frame-boundary commit handshake, so a frame never mixes two values.
//
// Optional feature: define SSD_LEADING_ZERO_BLANK_EN to blank leading-zero
// digits. Digit 0 is always shown.
//
// Parameters:
//   NUM_DIGITS  number of digits scanned (2..8)
//   PRESCALE    clk cycles per digit slot (>= 1)
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   en           scan enable, 0 turns the display off
//   load         request to display dataIn (strobe or level)
//   dataIn       value to display, nibble k on digit k
//   ldAck        one-cycle pulse when a loaded value reaches the display
//   frameDone    one-cycle pulse at each scan-frame wrap
//   nOut         nibble for the current digit, drives the decoder's nIn
//   digitSel_L   active-low digit enables, at most one bit low

module ssd_scan_controller #(
   parameter int NUM_DIGITS = 4,
   parameter int PRESCALE   = 50000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] dataIn,
   output logic                    ldAck,
   output logic                    frameDone,
   output logic [3:0]              nOut,
   output logic [NUM_DIGITS-1:0]   digitSel_L
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IW = $clog2(NUM_DIGITS);

   typedef enum logic {
      OFF  = 1'b0,
      SCAN = 1'b1
   } scanState_t;

   scanState_t              state;
   logic [IW-1:0]           idx;
   logic [CW-1:0]           cnt;
   logic [4*NUM_DIGITS-1:0] shadow;
   logic [4*NUM_DIGITS-1:0] holding;
   logic                    pending;

   logic                    tick;
   logic                    wrap;

   // A slot ends when the prescale counter reaches its last value; the frame
   // wraps when that happens on the last digit.
   always_comb begin
      tick = (cnt == CW'(PRESCALE - 1));
      wrap = tick && (idx == IW'(NUM_DIGITS - 1));
   end

   // Main controller. In OFF a load goes straight to the display because no
   // frame is in progress to tear. In SCAN loads are parked in holding and
   // only committed at the frame wrap, where a same-cycle load wins over the
   // parked value. Leaving SCAN keeps any parked value so it is committed
   // later. The en=0 assignments come last so they override the slot
   // advance while still letting a coincident wrap commit.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= OFF;
         idx       <= '0;
         cnt       <= '0;
         shadow    <= '0;
         holding   <= '0;
         pending   <= 1'b0;
         ldAck     <= 1'b0;
         frameDone <= 1'b0;
      end else begin
         ldAck     <= 1'b0;
         frameDone <= 1'b0;
         case (state)
            OFF: begin
               idx <= '0;
               cnt <= '0;
               if (load) begin
                  shadow  <= dataIn;
                  pending <= 1'b0;
                  ldAck   <= 1'b1;
               end
               if (en) begin
                  state <= SCAN;
               end
            end
            SCAN: begin
               if (tick) begin
                  cnt <= '0;
                  if (wrap) begin
                     idx <= '0;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
               if (wrap) begin
                  frameDone <= 1'b1;
                  if (pending || load) begin
                     shadow  <= load ? dataIn : holding;
                     pending <= 1'b0;
                     ldAck   <= 1'b1;
                  end
               end else if (load) begin
                  holding <= dataIn;
                  pending <= 1'b1;
               end
               if (!en) begin
                  state <= OFF;
                  idx   <= '0;
                  cnt   <= '0;
               end
            end
            default: begin
               state <= OFF;
            end
         endcase
      end
   end

`ifdef SSD_LEADING_ZERO_BLANK_EN
   logic [NUM_DIGITS-1:0] zeroFrom;

   // zeroFrom[k] is set when nibbles k and above of the shown value are all
   // zero, which makes digit k a leading zero.
   always_comb begin
      zeroFrom = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         zeroFrom[k] = ((shadow >> (4 * k)) == '0);
      end
   end
`endif

   // Display decode from registered state only. OFF shows nibble 0 on the
   // decoder with every digit disabled; SCAN enables the slot's digit.
   always_comb begin
      nOut       = shadow[3:0];
      digitSel_L = '1;
      if (state == SCAN) begin
         for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
               nOut = shadow[4*k +: 4];
`ifdef SSD_LEADING_ZERO_BLANK_EN
               digitSel_L[k] = (k > 0) && zeroFrom[k];
`else
               digitSel_L[k] = 1'b0;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_ssd_scan_controller.sv
// tb_ssd_scan_controller
//
// Directed bench for ssd_scan_controller with NUM_DIGITS=4, PRESCALE=3.
// Inputs change and outputs are checked 1 time unit after each rising edge.
// Expected values are worked out by hand from the slot timing: one digit
// slot lasts 3 cycles and a frame lasts 12 cycles.

module tb_ssd_scan_controller;

   localparam int ND = 4;
   localparam int PS = 3;

   logic          clk;
   logic          rst;
   logic          en;
   logic          load;
   logic [15:0]   dataIn;
   logic          ldAck;
   logic          frameDone;
   logic [3:0]    nOut;
   logic [ND-1:0] digitSel_L;

   int vectors;
   int miscompares;

   ssd_scan_controller #(
      .NUM_DIGITS(ND),
      .PRESCALE(PS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .load(load),
      .dataIn(dataIn),
      .ldAck(ldAck),
      .frameDone(frameDone),
      .nOut(nOut),
      .digitSel_L(digitSel_L)
   );

   // 10-unit clock period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance n rising edges and settle 1 unit past the last one.
   task automatic applyStimulus(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One comparison: count it, and count and report it if it differs.
   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Check the four display outputs in one call.
   task automatic checkAll(input string tag, input logic [3:0] expSel,
                           input logic [3:0] expN, input logic expAck,
                           input logic expFd);
      checkOutput({tag, ".sel"}, 16'(digitSel_L), 16'(expSel));
      checkOutput({tag, ".nOut"}, 16'(nOut), 16'(expN));
      checkOutput({tag, ".ldAck"}, 16'(ldAck), 16'(expAck));
      checkOutput({tag, ".frameDone"}, 16'(frameDone), 16'(expFd));
   endtask

   // Linear directed sequence. Edge numbers in comments count rising edges
   // after reset is released (E1 is the first).
   initial begin
      logic [3:0] expSel;
      vectors     = 0;
      miscompares = 0;
      rst    = 1'b1;
      en     = 1'b0;
      load   = 1'b0;
      dataIn = 16'h0000;
      applyStimulus(2);
      rst = 1'b0;
      checkAll("reset", 4'b1111, 4'h0, 1'b0, 1'b0);

      // Load in OFF together with enable: committed at once.
      en     = 1'b1;
      load   = 1'b1;
      dataIn = 16'h1234;
      applyStimulus(1);
      load = 1'b0;
      checkAll("E1.first", 4'b1110, 4'h4, 1'b1, 1'b0);
      applyStimulus(1);
      checkAll("E2.hold0", 4'b1110, 4'h4, 1'b0, 1'b0);
      applyStimulus(2);
      checkAll("E4.dig1", 4'b1101, 4'h3, 1'b0, 1'b0);
      applyStimulus(3);
      checkAll("E7.dig2", 4'b1011, 4'h2, 1'b0, 1'b0);
      applyStimulus(3);
      checkAll("E10.dig3", 4'b0111, 4'h1, 1'b0, 1'b0);
      applyStimulus(3);
      checkAll("E13.wrap", 4'b1110, 4'h4, 1'b0, 1'b1);
      applyStimulus(1);
      checkAll("E14.after", 4'b1110, 4'h4, 1'b0, 1'b0);

      // Load ABCD during digit 1: current frame keeps 1234.
      applyStimulus(2);
      load   = 1'b1;
      dataIn = 16'hABCD;
      applyStimulus(1);
      load = 1'b0;
      checkAll("E17.queued", 4'b1101, 4'h3, 1'b0, 1'b0);
      applyStimulus(2);
      checkAll("E19.old2", 4'b1011, 4'h2, 1'b0, 1'b0);
      applyStimulus(3);
      checkAll("E22.old1", 4'b0111, 4'h1, 1'b0, 1'b0);
      applyStimulus(3);
      checkAll("E25.commit", 4'b1110, 4'hD, 1'b1, 1'b1);
      applyStimulus(3);
      checkAll("E28.C", 4'b1101, 4'hC, 1'b0, 1'b0);
      applyStimulus(3);
      checkAll("E31.B", 4'b1011, 4'hB, 1'b0, 1'b0);
      applyStimulus(3);
      checkAll("E34.A", 4'b0111, 4'hA, 1'b0, 1'b0);
      applyStimulus(3);
      checkAll("E37.wrap", 4'b1110, 4'hD, 1'b0, 1'b1);

      // Two loads in one frame: last wins, one acknowledge.
      load   = 1'b1;
      dataIn = 16'h1111;
      applyStimulus(1);
      dataIn = 16'h2222;
      applyStimulus(1);
      load = 1'b0;
      checkAll("E39.twice", 4'b1110, 4'hD, 1'b0, 1'b0);
      applyStimulus(9);
      checkAll("E48.preWrap", 4'b0111, 4'hA, 1'b0, 1'b0);
      applyStimulus(1);
      checkAll("E49.commit", 4'b1110, 4'h2, 1'b1, 1'b1);
      applyStimulus(1);
      checkAll("E50.oneAck", 4'b1110, 4'h2, 1'b0, 1'b0);
      applyStimulus(2);
      checkAll("E52.dig1", 4'b1101, 4'h2, 1'b0, 1'b0);

      // Disable at digit 2, load in OFF, re-enable from digit 0.
      applyStimulus(3);
      en = 1'b0;
      applyStimulus(1);
      checkAll("E56.off", 4'b1111, 4'h2, 1'b0, 1'b0);
      load   = 1'b1;
      dataIn = 16'h5678;
      applyStimulus(1);
      load = 1'b0;
      en   = 1'b1;
      checkAll("E57.offLoad", 4'b1111, 4'h8, 1'b1, 1'b0);
      applyStimulus(1);
      checkAll("E58.restart", 4'b1110, 4'h8, 1'b0, 1'b0);
      applyStimulus(2);
      checkAll("E60.slot0", 4'b1110, 4'h8, 1'b0, 1'b0);
      applyStimulus(1);
      checkAll("E61.dig1", 4'b1101, 4'h7, 1'b0, 1'b0);

      // Reset with a queued value at digit 3: value is discarded.
      applyStimulus(6);
      checkAll("E67.dig3", 4'b0111, 4'h5, 1'b0, 1'b0);
      load   = 1'b1;
      dataIn = 16'h9999;
      applyStimulus(1);
      load = 1'b0;
      rst  = 1'b1;
      applyStimulus(1);
      rst = 1'b0;
      checkAll("E69.rst", 4'b1111, 4'h0, 1'b0, 1'b0);
      applyStimulus(1);
      checkAll("E70.rescan", 4'b1110, 4'h0, 1'b0, 1'b0);
      applyStimulus(12);
      checkAll("E82.noAck", 4'b1110, 4'h0, 1'b0, 1'b1);

      // Disable and load on the wrap cycle: commit and frameDone still occur.
      applyStimulus(11);
      en     = 1'b0;
      load   = 1'b1;
      dataIn = 16'h4321;
      applyStimulus(1);
      load = 1'b0;
      checkAll("E94.wrapOff", 4'b1111, 4'h1, 1'b1, 1'b1);
      applyStimulus(1);
      checkAll("E95.quiet", 4'b1111, 4'h1, 1'b0, 1'b0);

      // Leading-zero value 0050.
      load   = 1'b1;
      en     = 1'b1;
      dataIn = 16'h0050;
      applyStimulus(1);
      load = 1'b0;
      checkAll("E96.lz0", 4'b1110, 4'h0, 1'b1, 1'b0);
      applyStimulus(3);
      checkAll("E99.lz1", 4'b1101, 4'h5, 1'b0, 1'b0);
      applyStimulus(3);
`ifdef SSD_LEADING_ZERO_BLANK_EN
      expSel = 4'b1111;
`else
      expSel = 4'b1011;
`endif
      checkAll("E102.lz2", expSel, 4'h0, 1'b0, 1'b0);
      load   = 1'b1;
      dataIn = 16'h0000;
      applyStimulus(1);
      load = 1'b0;
      applyStimulus(2);
`ifdef SSD_LEADING_ZERO_BLANK_EN
      expSel = 4'b1111;
`else
      expSel = 4'b0111;
`endif
      checkAll("E105.lz3", expSel, 4'h0, 1'b0, 1'b0);
      applyStimulus(3);
      checkAll("E108.zero0", 4'b1110, 4'h0, 1'b1, 1'b1);
      applyStimulus(3);
`ifdef SSD_LEADING_ZERO_BLANK_EN
      expSel = 4'b1111;
`else
      expSel = 4'b1101;
`endif
      checkAll("E111.zero1", expSel, 4'h0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
